// File: rtl/aegis_alert_pkg.sv
// Shared constants and types for the alert stream decoder: 2-bit alert codes,
// the ASCII bytes recognised on the input stream, and the frame FSM states.
package aegis_alert_pkg;

    localparam int unsigned CODE_W  = 2;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [CODE_W-1:0] CODE_NONE = 2'b00;
    localparam logic [CODE_W-1:0] CODE_R    = 2'b01;
    localparam logic [CODE_W-1:0] CODE_P    = 2'b10;
    localparam logic [CODE_W-1:0] CODE_B    = 2'b11;

    localparam logic [BYTE_W-1:0] ASCII_R  = 8'h52;
    localparam logic [BYTE_W-1:0] ASCII_P  = 8'h50;
    localparam logic [BYTE_W-1:0] ASCII_B  = 8'h42;
    localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
    localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HAVE_CHAR = 2'd1,
        ST_SKIP      = 2'd2
    } state_e;

endpackage

// File: rtl/alert_char_lookup.sv
// Combinational byte-to-code lookup for alert letters.
//   data : ASCII byte under test
//   code : 01 'R', 10 'P', 11 'B', 00 for any other byte (case-sensitive)
module alert_char_lookup
    import aegis_alert_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        code = CODE_NONE;
        unique case (data)
            ASCII_R: code = CODE_R;
            ASCII_P: code = CODE_P;
            ASCII_B: code = CODE_B;
            default: code = CODE_NONE;
        endcase
    end

endmodule

// File: rtl/alert_stream_decoder.sv
// Decodes an ASCII alert stream of single-letter frames ('R','P','B' then LF,
// CR ignored everywhere) into 2-bit alert codes through a single-entry output
// register, with saturating per-type delivery counters and an error counter.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_data    : byte offered; accepted when in_valid && in_ready
//   in_ready            : !out_valid || out_ready, held low during reset
//   out_valid/out_code  : decoded alert; taken when out_valid && out_ready
//   err_pulse           : one-cycle pulse per malformed frame
//   cnt_r/cnt_p/cnt_b   : delivered alerts per type
//   err_count           : malformed frames seen
module alert_stream_decoder
    import aegis_alert_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [1:0]        out_code,
    input  logic              out_ready,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  cnt_r,
    output logic [CNT_W-1:0]  cnt_p,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [ERR_W-1:0]  err_count
);

    state_e             state;
    logic [CODE_W-1:0]  held_code;
    logic [CODE_W-1:0]  lut_code;

    logic take_c;
    logic is_lf_c;
    logic is_letter_c;
    logic err_now_c;
    logic load_now_c;
    logic accept_out_c;

    alert_char_lookup u_lookup (
        .data (in_data),
        .code (lut_code)
    );

    // Ready is a pure function of the output register so a full entry being
    // drained this cycle still lets a new byte in (no bubble).
    assign in_ready     = !rst && (!out_valid || out_ready);
    assign accept_out_c = out_valid && out_ready;

    // CR bytes are consumed but never reach the frame logic.
    assign take_c      = in_valid && in_ready && (in_data != ASCII_CR);
    assign is_lf_c     = (in_data == ASCII_LF);
    assign is_letter_c = (lut_code != CODE_NONE);

    assign err_now_c  = take_c &&
                        (((state == ST_IDLE) && !is_letter_c && !is_lf_c) ||
                         ((state == ST_HAVE_CHAR) && !is_lf_c));
    assign load_now_c = take_c && (state == ST_HAVE_CHAR) && is_lf_c;

    // Frame FSM, output register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            held_code <= CODE_NONE;
            out_valid <= 1'b0;
            out_code  <= CODE_NONE;
            err_pulse <= 1'b0;
            cnt_r     <= '0;
            cnt_p     <= '0;
            cnt_b     <= '0;
            err_count <= '0;
        end else begin
            err_pulse <= err_now_c;
            if (err_now_c && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end

            // Count the entry leaving the register; a same-cycle load below
            // overrides the clear of out_valid.
            if (accept_out_c) begin
                out_valid <= 1'b0;
                unique case (out_code)
                    CODE_R:  if (cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
                    CODE_P:  if (cnt_p != '1) cnt_p <= cnt_p + CNT_W'(1);
                    CODE_B:  if (cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
                    default: ;
                endcase
            end

            if (load_now_c) begin
                out_valid <= 1'b1;
                out_code  <= held_code;
            end

            if (take_c) begin
                unique case (state)
                    ST_IDLE: begin
                        if (is_letter_c) begin
                            held_code <= lut_code;
                            state     <= ST_HAVE_CHAR;
                        end else if (!is_lf_c) begin
                            state <= ST_SKIP;
                        end
                    end
                    ST_HAVE_CHAR: begin
                        held_code <= CODE_NONE;
                        state     <= is_lf_c ? ST_IDLE : ST_SKIP;
                    end
                    ST_SKIP: begin
                        if (is_lf_c) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alert_stream_decoder.sv
// Directed bench for alert_stream_decoder: a default build plus a narrow
// build (CNT_W=4, ERR_W=2) sharing the same stimulus to hit saturation.
module tb_alert_stream_decoder;
    import aegis_alert_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready, out_valid, err_pulse;
    logic [1:0]  out_code;
    logic [15:0] cnt_r, cnt_p, cnt_b;
    logic [7:0]  err_count;

    logic        s_in_ready, s_out_valid, s_err_pulse;
    logic [1:0]  s_out_code;
    logic [3:0]  s_cnt_r, s_cnt_p, s_cnt_b;
    logic [1:0]  s_err_count;

    int n_cmp = 0;
    int n_err = 0;

    alert_stream_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_code(out_code),
        .out_ready(out_ready), .err_pulse(err_pulse), .cnt_r(cnt_r),
        .cnt_p(cnt_p), .cnt_b(cnt_b), .err_count(err_count)
    );

    alert_stream_decoder #(.CNT_W(4), .ERR_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_code(s_out_code),
        .out_ready(out_ready), .err_pulse(s_err_pulse), .cnt_r(s_cnt_r),
        .cnt_p(s_cnt_p), .cnt_b(s_cnt_b), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_rdy(input string tag, input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        chk(tag, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_in_ready",  32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_code",  32'(out_code), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_cnt_r",     32'(cnt_r), 0);
        chk("rst_err_count", 32'(err_count), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // 'R',LF: output one cycle after LF, counted after acceptance
        send(ASCII_R);
        send(ASCII_LF);
        chk("r_out_valid", 32'(out_valid), 1);
        chk("r_out_code",  32'(out_code), 1);
        chk("r_cnt_before", 32'(cnt_r), 0);
        tick();
        chk("r_out_drained", 32'(out_valid), 0);
        chk("r_cnt_r", 32'(cnt_r), 1);
        chk("r_err_count", 32'(err_count), 0);

        // 'B',CR,LF,'P',LF back-to-back with ready held high
        send_rdy("bp_rdy_b", ASCII_B);
        send_rdy("bp_rdy_cr", ASCII_CR);
        send_rdy("bp_rdy_lf1", ASCII_LF);
        chk("b_out_valid", 32'(out_valid), 1);
        chk("b_out_code",  32'(out_code), 3);
        send_rdy("bp_rdy_p", ASCII_P);
        chk("b_drained", 32'(out_valid), 0);
        chk("b_cnt_b", 32'(cnt_b), 1);
        send_rdy("bp_rdy_lf2", ASCII_LF);
        chk("p_out_valid", 32'(out_valid), 1);
        chk("p_out_code",  32'(out_code), 2);
        tick();
        chk("p_cnt_p", 32'(cnt_p), 1);

        // Malformed frames: 'X',junk,LF then 'R','P',LF
        send(8'h58);
        chk("x_err_pulse", 32'(err_pulse), 1);
        chk("x_err_count", 32'(err_count), 1);
        send(8'h51);
        chk("skip_no_err", 32'(err_pulse), 0);
        chk("skip_err_count", 32'(err_count), 1);
        send(ASCII_LF);
        send(ASCII_R);
        send(ASCII_P);
        chk("rp_err_pulse", 32'(err_pulse), 1);
        chk("rp_err_count", 32'(err_count), 2);
        send(ASCII_LF);
        chk("rp_pulse_clear", 32'(err_pulse), 0);
        chk("rp_no_output", 32'(out_valid), 0);

        // Backpressure: entry held, input stalled, then drained and replaced
        out_ready = 1'b0;
        send(ASCII_P);
        send(ASCII_LF);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_out_code", 32'(out_code), 2);
        in_valid = 1'b1; in_data = ASCII_R;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 0);
        tick();
        chk("bp_hold1", 32'(out_code), 2);
        tick();
        chk("bp_hold2_valid", 32'(out_valid), 1);
        chk("bp_hold2_code", 32'(out_code), 2);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        chk("bp_drained", 32'(out_valid), 0);
        chk("bp_cnt_p", 32'(cnt_p), 2);
        send(ASCII_LF);
        chk("bp_r_valid", 32'(out_valid), 1);
        chk("bp_r_code", 32'(out_code), 1);
        tick();
        chk("bp_cnt_r", 32'(cnt_r), 2);

        // Lower-case letter and doubled letter; narrow error counter saturates
        send(8'h72);
        chk("lc_err_count", 32'(err_count), 3);
        chk("lc_s_err_count", 32'(s_err_count), 3);
        send(ASCII_LF);
        send(ASCII_R);
        send(ASCII_R);
        chk("rr_err_pulse", 32'(err_pulse), 1);
        chk("rr_err_count", 32'(err_count), 4);
        chk("rr_s_err_sat", 32'(s_err_count), 3);
        send(ASCII_LF);
        send(ASCII_LF);
        chk("empty_no_err", 32'(err_pulse), 0);
        chk("empty_no_out", 32'(out_valid), 0);
        chk("empty_err_count", 32'(err_count), 4);

        // Reset drops a pending output entry
        out_ready = 1'b0;
        send(ASCII_R);
        send(ASCII_LF);
        chk("pend_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        chk("pend_rst_valid", 32'(out_valid), 0);
        chk("pend_rst_in_ready", 32'(in_ready), 0);
        chk("pend_rst_cnt_r", 32'(cnt_r), 0);
        chk("pend_rst_cnt_p", 32'(cnt_p), 0);
        chk("pend_rst_err", 32'(err_count), 0);
        chk("pend_rst_s_err", 32'(s_err_count), 0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset mid-frame: trailing LF alone yields nothing
        send(ASCII_B);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_code", 32'(out_code), 0);
        rst = 1'b0;
        send(ASCII_LF);
        chk("mid_lf_valid", 32'(out_valid), 0);
        chk("mid_lf_pulse", 32'(err_pulse), 0);
        tick();
        chk("mid_err_count", 32'(err_count), 0);
        chk("mid_cnt_b", 32'(cnt_b), 0);

        // Counter saturation on the narrow build
        for (int i = 0; i < 15; i++) begin
            send(ASCII_B);
            send(ASCII_LF);
        end
        tick();
        chk("sat15_cnt_b", 32'(cnt_b), 15);
        chk("sat15_s_cnt_b", 32'(s_cnt_b), 15);
        send(ASCII_B);
        send(ASCII_LF);
        tick();
        chk("sat16_cnt_b", 32'(cnt_b), 16);
        chk("sat16_s_cnt_b", 32'(s_cnt_b), 15);
        chk("sat_err_count", 32'(err_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alert_stream_decoder.md
ALERT_STREAM_DECODER -- requirements
Module: alert_stream_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of per-type alert counters.
REQ-002 The block SHALL have parameter ERR_W, default 8, width of the error counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  ASCII byte offered.
REQ-006 The block SHALL have port in_data  input  8  ASCII byte.
REQ-007 The block SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 The block SHALL have port out_valid  output  1  decoded alert available.
REQ-009 The block SHALL have port out_code  output  2  01=Rule, 10=Pattern, 11=Both; never 00 while out_valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-011 The block SHALL have port err_pulse  output  1  one-cycle pulse per malformed frame.
REQ-012 The block SHALL have ports cnt_r, cnt_p, cnt_b  output  CNT_W each  delivered alerts per type.
REQ-013 The block SHALL have port err_count  output  ERR_W  malformed frames seen.

Function
REQ-014 Frame format SHALL be exactly one of 'R'(0x52), 'P'(0x50), 'B'(0x42) followed by LF (0x0A); CR (0x0D) SHALL be discarded in every state without effect.
REQ-015 FSM states SHALL be IDLE, HAVE_CHAR, SKIP.
REQ-016 IDLE: valid letter -> latch code, go HAVE_CHAR; LF -> stay IDLE, no output, no error (empty line); any other byte -> error, go SKIP.
REQ-017 HAVE_CHAR: LF -> load output register with latched code, go IDLE; any other non-CR byte (including a second letter) -> error, discard latched code, go SKIP.
REQ-018 SKIP: discard bytes until LF, then go IDLE; no further errors raised within the same frame.
REQ-019 An error SHALL assert err_pulse for exactly the cycle after the offending byte is accepted and increment err_count, saturating at all-ones.
REQ-020 in_ready SHALL equal !out_valid || out_ready (single-entry output register, full-throughput when consumer ready).
REQ-021 Latency: LF accepted in cycle N SHALL give out_valid=1 in cycle N+1.
REQ-022 out_valid and out_code SHALL hold stable until accepted; a new frame completing in the same cycle as acceptance SHALL replace the entry with no bubble.
REQ-023 cnt_r/cnt_p/cnt_b SHALL increment on the cycle after output acceptance for the delivered code, saturating at all-ones.
REQ-024 Bytes SHALL be case-sensitive; lower-case letters are errors.

Reset
REQ-025 While rst=1 the FSM SHALL enter IDLE, and out_valid, out_code, err_pulse, all counters SHALL be 0; in_ready SHALL be 0 during reset cycle and 1 the cycle after.
REQ-026 Reset mid-frame SHALL drop the partial frame and the pending output entry with no error counted.

Structure
REQ-027 A shared package aegis_alert_pkg SHALL hold 2-bit code constants (CODE_NONE/R/P/B), ASCII constants (R, P, B, LF, CR) and the FSM state enum.
REQ-028 A combinational sub-module alert_char_lookup (byte -> 2-bit code, 00 = not a letter) SHALL be instantiated; FSM, output register and counters live in the top.

Verification
REQ-029 Bytes 'R',LF with out_ready=1 -> out_valid one cycle after LF, out_code=01, cnt_r=1 one cycle after acceptance, err_count=0.
REQ-030 Stream 'B',CR,LF,'P',LF back-to-back, out_ready=1 -> codes 11 then 10 in consecutive frames, in_ready never drops.
REQ-031 'X',LF then 'R','P',LF -> two err_pulse cycles, err_count=2, no output.
REQ-032 out_ready=0, 'P',LF,'R' -> out_code=10 held, in_ready=0 after first output loaded; raise out_ready -> 10 delivered, then 'R',LF yields 01.
REQ-033 rst asserted after 'B' (before LF) -> all outputs 0; following LF alone produces no output and no error.
REQ-034 Force cnt_b to all-ones (CNT_W=4 build), deliver 'B',LF -> cnt_b stays 15.
